// File: rtl/mips_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU op encodings,
// control-bundle layout and the canonical NOP.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam int CTRL_W          = 10;
    localparam int CTRL_REG_WRITE  = 9;
    localparam int CTRL_MEM_READ   = 8;
    localparam int CTRL_MEM_WRITE  = 7;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_REG_DST    = 4;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_ALU_OP_HI  = 2;
    localparam int CTRL_ALU_OP_LO  = 1;
    localparam int CTRL_ILLEGAL    = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // Field order matches the CTRL_* bit indices above.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    function automatic logic [5:0] instr_opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// Fetch-side, register-file/sign-extender and execute-side signals of the ID stage.
interface id_stage_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int IMM_W      = 16,
    parameter int REG_ADDR_W = 5
);
    logic [DATA_W-1:0]     if_instr;
    logic [DATA_W-1:0]     if_pc4;
    logic                  if_valid;
    logic                  flush;
    logic [IMM_W-1:0]      id_imm16;
    logic [DATA_W-1:0]     se_imm32;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [DATA_W-1:0]     rf_rd1;
    logic [DATA_W-1:0]     rf_rd2;
    logic                  pc_write;
    logic                  ex_valid;
    logic [DATA_W-1:0]     ex_pc4;
    logic [DATA_W-1:0]     ex_rd1;
    logic [DATA_W-1:0]     ex_rd2;
    logic [DATA_W-1:0]     ex_imm32;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [5:0]            ex_funct;
    logic [9:0]            ex_ctrl;

    modport master (
        output if_instr, if_pc4, if_valid, flush, se_imm32, rf_rd1, rf_rd2,
        input  id_imm16, id_rs, id_rt, pc_write, ex_valid, ex_pc4, ex_rd1,
               ex_rd2, ex_imm32, ex_rs, ex_rt, ex_rd, ex_funct, ex_ctrl
    );

    modport slave (
        input  if_instr, if_pc4, if_valid, flush, se_imm32, rf_rd1, rf_rd2,
        output id_imm16, id_rs, id_rt, pc_write, ex_valid, ex_pc4, ex_rd1,
               ex_rd2, ex_imm32, ex_rs, ex_rt, ex_rd, ex_funct, ex_ctrl
    );
endinterface

// File: rtl/id_stage_pipe_main_control.sv
// Main decoder: opcode plus slot valid to the 10-bit control bundle.
module main_control
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       valid,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        if (valid) begin
            case (opcode)
                OP_RTYPE: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                    ctrl.alu_op    = ALU_OP_FUNCT;
                end
                OP_LW: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_read   = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.alu_src    = 1'b1;
                    ctrl.alu_op     = ALU_OP_ADD;
                end
                OP_SW: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.alu_op    = ALU_OP_ADD;
                end
                OP_BEQ: begin
                    ctrl.branch = 1'b1;
                    ctrl.alu_op = ALU_OP_SUB;
                end
                OP_ADDI: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.alu_op    = ALU_OP_ADD;
                end
                default: ctrl.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with IF/ID and ID/EX pipeline registers, load-use stall and
// branch flush. The sign extender and register file sit outside this block.
module id_stage_pipe
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int IMM_W      = 16,
    parameter int REG_ADDR_W = 5
) (
    input logic           clk,
    input logic           rst,
    id_stage_pipe_if.slave bus
);

    logic [DATA_W-1:0]     ifid_instr;
    logic [DATA_W-1:0]     ifid_pc4;
    logic                  ifid_valid;

    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [5:0]            id_funct;
    ctrl_t                 id_ctrl;
    logic                  stall;
    logic                  unused_shamt;

    logic                  ex_valid_q;
    logic [DATA_W-1:0]     ex_pc4_q;
    logic [DATA_W-1:0]     ex_rd1_q;
    logic [DATA_W-1:0]     ex_rd2_q;
    logic [DATA_W-1:0]     ex_imm32_q;
    logic [REG_ADDR_W-1:0] ex_rs_q;
    logic [REG_ADDR_W-1:0] ex_rt_q;
    logic [REG_ADDR_W-1:0] ex_rd_q;
    logic [5:0]            ex_funct_q;
    ctrl_t                 ex_ctrl_q;

    assign id_rs        = ifid_instr[21 +: REG_ADDR_W];
    assign id_rt        = ifid_instr[16 +: REG_ADDR_W];
    assign id_rd        = ifid_instr[11 +: REG_ADDR_W];
    assign id_funct     = ifid_instr[5:0];
    assign unused_shamt = ^ifid_instr[10:6];

    main_control u_main_control (
        .opcode (instr_opcode(ifid_instr[31:0])),
        .valid  (ifid_valid),
        .ctrl   (id_ctrl)
    );

    // A load into $0 never produces a real dependency, so it never stalls.
    assign stall = ex_valid_q & ex_ctrl_q.mem_read & (ex_rt_q != '0) & ifid_valid
                 & ((ex_rt_q == id_rs) | (ex_rt_q == id_rt));

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_instr <= NOP;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else if (bus.flush) begin
            ifid_instr <= NOP;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            ifid_instr <= bus.if_instr;
            ifid_pc4   <= bus.if_pc4;
            ifid_valid <= bus.if_valid;
        end
    end

    // Operand fields load every cycle; a bubble is marked purely by valid and ctrl.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_pc4_q   <= '0;
            ex_rd1_q   <= '0;
            ex_rd2_q   <= '0;
            ex_imm32_q <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            ex_funct_q <= '0;
            ex_ctrl_q  <= '0;
        end else begin
            ex_valid_q <= ifid_valid & ~stall & ~bus.flush;
            ex_ctrl_q  <= (stall | bus.flush) ? ctrl_t'('0) : id_ctrl;
            ex_pc4_q   <= ifid_pc4;
            ex_rd1_q   <= bus.rf_rd1;
            ex_rd2_q   <= bus.rf_rd2;
            ex_imm32_q <= bus.se_imm32;
            ex_rs_q    <= id_rs;
            ex_rt_q    <= id_rt;
            ex_rd_q    <= id_rd;
            ex_funct_q <= id_funct;
        end
    end

    assign bus.id_imm16 = ifid_instr[IMM_W-1:0];
    assign bus.id_rs    = id_rs;
    assign bus.id_rt    = id_rt;
    assign bus.pc_write = rst | bus.flush | ~stall;
    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_pc4   = ex_pc4_q;
    assign bus.ex_rd1   = ex_rd1_q;
    assign bus.ex_rd2   = ex_rd2_q;
    assign bus.ex_imm32 = ex_imm32_q;
    assign bus.ex_rs    = ex_rs_q;
    assign bus.ex_rt    = ex_rt_q;
    assign bus.ex_rd    = ex_rd_q;
    assign bus.ex_funct = ex_funct_q;
    assign bus.ex_ctrl  = ex_ctrl_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe with a scoreboard of expected ID/EX contents.
module tb_id_stage_pipe;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [9:0]  ctrl;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   held;
    logic [31:0] pc4;
    exp_t sb[$];

    id_stage_pipe_if bus ();

    id_stage_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External register file and sign extender models.
    always_comb begin
        bus.rf_rd1   = 32'h1000_0000 | {27'b0, bus.id_rs};
        bus.rf_rd2   = 32'h2000_0000 | {27'b0, bus.id_rt};
        bus.se_imm32 = {{16{bus.id_imm16[15]}}, bus.id_imm16};
    end

    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] p4);
        exp_t e;
        e.pc4   = p4;
        e.rs    = instr[25:21];
        e.rt    = instr[20:16];
        e.rd    = instr[15:11];
        e.funct = instr[5:0];
        e.rd1   = 32'h1000_0000 | {27'b0, instr[25:21]};
        e.rd2   = 32'h2000_0000 | {27'b0, instr[20:16]};
        e.imm   = {{16{instr[15]}}, instr[15:0]};
        case (instr[31:26])
            6'h00:   e.ctrl = 10'b1000010100;
            6'h23:   e.ctrl = 10'b1101100000;
            6'h2B:   e.ctrl = 10'b0010100000;
            6'h04:   e.ctrl = 10'b0000001010;
            6'h08:   e.ctrl = 10'b1000100000;
            default: e.ctrl = 10'b0000000001;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", name, obs, expv);
        end
    endtask

    task automatic check_ex();
        exp_t obs;
        exp_t e;
        if (bus.ex_valid === 1'b1) begin
            obs = {bus.ex_pc4, bus.ex_rd1, bus.ex_rd2, bus.ex_imm32, bus.ex_rs,
                   bus.ex_rt, bus.ex_rd, bus.ex_funct, bus.ex_ctrl};
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $error("FAIL sb_unexpected observed=%h expected=none", obs);
            end else begin
                e = sb.pop_front();
                assert (obs === e) else begin
                    fails++;
                    $error("FAIL sb_ex observed=%h expected=%h", obs, e);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_ex();
    endtask

    // Present one fetch slot, holding it while pc_write is low (bounded).
    task automatic issue(input logic [31:0] instr, input logic valid, output int h);
        bus.if_instr = instr;
        bus.if_valid = valid;
        bus.if_pc4   = pc4;
        h = 0;
        while (bus.pc_write !== 1'b1 && h < 8) begin
            tick();
            h++;
        end
        if (h >= 8) begin
            tests++;
            fails++;
            $error("FAIL issue_timeout observed=%0d expected=<8", h);
        end
        tick();
        if (valid) sb.push_back(model(instr, pc4));
        pc4 = pc4 + 32'd4;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        pc4   = 32'h0000_0104;
        rst   = 1'b1;
        bus.flush    = 1'b0;
        bus.if_instr = 32'h0;
        bus.if_pc4   = 32'h0;
        bus.if_valid = 1'b0;
        tick();
        tick();
        chk("rst_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
        chk("rst_ex_ctrl", {22'b0, bus.ex_ctrl}, 32'd0);
        chk("rst_ex_pc4_rd1", bus.ex_pc4 | bus.ex_rd1 | bus.ex_rd2 | bus.ex_imm32, 32'd0);
        chk("rst_ex_fields", {11'b0, bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_funct}, 32'd0);
        chk("rst_pc_write", {31'b0, bus.pc_write}, 32'd1);
        rst = 1'b0;

        // lw $2,4($1) then dependent add $3,$2,$4
        issue(32'h8C220004, 1'b1, held);
        issue(32'h00441820, 1'b1, held);
        chk("lu_pc_write_low", {31'b0, bus.pc_write}, 32'd0);
        bus.if_valid = 1'b0;
        tick();
        chk("lu_bubble_valid", {31'b0, bus.ex_valid}, 32'd0);
        chk("lu_bubble_ctrl", {22'b0, bus.ex_ctrl}, 32'd0);
        chk("lu_pc_write_back", {31'b0, bus.pc_write}, 32'd1);
        tick();
        chk("lu_add_valid", {31'b0, bus.ex_valid}, 32'd1);
        chk("lu_add_rs", {27'b0, bus.ex_rs}, 32'd2);

        // load into $0 followed by a use of $0
        issue(32'h8C200000, 1'b1, held);
        issue(32'h00041820, 1'b1, held);
        issue(32'h0, 1'b0, held);
        chk("ld0_no_stall", held, 32'd0);

        // addi $5,$0,-1
        issue(32'h2005FFFF, 1'b1, held);
        issue(32'h0, 1'b0, held);
        chk("addi_imm32", bus.ex_imm32, 32'hFFFF_FFFF);
        chk("addi_ctrl", {22'b0, bus.ex_ctrl}, 32'b1000100000);

        // sw, beq, R-type with no hazards
        issue(32'hAC220008, 1'b1, held);
        issue(32'h1022FFFE, 1'b1, held);
        issue(32'h00851020, 1'b1, held);
        issue(32'h0, 1'b0, held);
        chk("mix_no_stall", held, 32'd0);

        // back-to-back dependent loads, then a use of the second load
        issue(32'h8C220000, 1'b1, held);
        issue(32'h8C430000, 1'b1, held);
        issue(32'h00602020, 1'b1, held);
        chk("b2b_stall1", held, 32'd1);
        issue(32'h0, 1'b0, held);
        chk("b2b_stall2", held, 32'd1);

        // unknown opcode 0x3F, valid then invalid
        issue(32'hFC000000, 1'b1, held);
        issue(32'hFC000000, 1'b0, held);
        chk("illegal_ctrl", {22'b0, bus.ex_ctrl}, 32'd1);
        issue(32'h0, 1'b0, held);
        chk("illegal_inv_valid", {31'b0, bus.ex_valid}, 32'd0);
        chk("illegal_inv_ctrl", {22'b0, bus.ex_ctrl}, 32'd0);

        // flush coinciding with a load-use stall
        issue(32'h8C220004, 1'b1, held);
        issue(32'h00441820, 1'b1, held);
        bus.flush    = 1'b1;
        bus.if_instr = 32'hAC220008;
        bus.if_valid = 1'b1;
        #1;
        chk("fl_pc_write", {31'b0, bus.pc_write}, 32'd1);
        tick();
        if (sb.size() != 0) void'(sb.pop_front());
        bus.flush    = 1'b0;
        bus.if_valid = 1'b0;
        chk("fl_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
        chk("fl_ifid_empty", {27'b0, bus.id_rs} | {16'b0, bus.id_imm16}, 32'd0);
        tick();
        chk("fl_ex_valid2", {31'b0, bus.ex_valid}, 32'd0);

        // reset while stalled
        issue(32'h8C220004, 1'b1, held);
        issue(32'h00441820, 1'b1, held);
        chk("rs_pre_stall", {31'b0, bus.pc_write}, 32'd0);
        rst = 1'b1;
        bus.if_valid = 1'b0;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("rs_pc_write", {31'b0, bus.pc_write}, 32'd1);
        chk("rs_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
        chk("rs_ifid_empty", {27'b0, bus.id_rs} | {16'b0, bus.id_imm16}, 32'd0);
        tick();
        chk("rs_ex_valid2", {31'b0, bus.ex_valid}, 32'd0);

        tick();
        tick();
        chk("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
